// File: rtl/zion_riscv_isa_lib_sft_de_stage_if.sv
// Handshake bundle for the shift decode stage: upstream instruction side and
// downstream decoded-shift side.
interface zion_riscv_isa_lib_sft_de_stage_if #(parameter int RV64 = 0);
  localparam int XLEN = (RV64 != 0) ? 64 : 32;
  localparam int OPW  = (RV64 != 0) ? 4 : 3;
  localparam int SW   = (RV64 != 0) ? 6 : 5;

  logic            up_vld;
  logic            up_rdy;
  logic [31:0]     inst;
  logic [XLEN-1:0] rs1_dat;
  logic [XLEN-1:0] rs2_dat;
  logic            dn_vld;
  logic            dn_rdy;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] s1;
  logic [SW-1:0]   s2;
  logic [4:0]      rd_idx;
  logic            illegal;

  modport slave (
    input  up_vld, inst, rs1_dat, rs2_dat, dn_rdy,
    output up_rdy, dn_vld, op, s1, s2, rd_idx, illegal
  );

  modport master (
    output up_vld, inst, rs1_dat, rs2_dat, dn_rdy,
    input  up_rdy, dn_vld, op, s1, s2, rd_idx, illegal
  );
endinterface

// File: rtl/zion_riscv_isa_lib_sft_de_stage.sv
// RISC-V shift-instruction decode stage with a 2-entry skid buffer
// (output register + skid register) between decode and execution.
module zion_riscv_isa_lib_sft_de_stage #(
  parameter int RV64 = 0
) (
  input logic iClk,
  input logic iRst_n,
  zion_riscv_isa_lib_sft_de_stage_if.slave bus
);
  localparam int XLEN = (RV64 != 0) ? 64 : 32;
  localparam int OPW  = (RV64 != 0) ? 4 : 3;
  localparam int SW   = (RV64 != 0) ? 6 : 5;
  localparam bit WIDE = (RV64 != 0);

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] s1;
    logic [SW-1:0]   s2;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  logic [2:0] f3;
  logic       cls_ok;
  logic       is_reg;
  logic       is_w;
  logic       wide_imm;
  logic       hi_zero;
  logic       hi_sra;
  logic       left;
  logic       right;
  logic       legal;
  logic [5:0] raw_amt;
  logic [5:0] amt;
  logic [3:0] op_full;
  entry_t     dec;

  // Non-W immediates on RV64 carry a 6-bit shamt, so only inst[31:26] is funct.
  always_comb begin
    f3     = bus.inst[14:12];
    cls_ok = 1'b0;
    is_reg = 1'b0;
    is_w   = 1'b0;
    case (bus.inst[6:0])
      7'b0010011: cls_ok = 1'b1;
      7'b0110011: begin
        cls_ok = 1'b1;
        is_reg = 1'b1;
      end
      7'b0011011: begin
        cls_ok = WIDE;
        is_w   = 1'b1;
      end
      7'b0111011: begin
        cls_ok = WIDE;
        is_reg = 1'b1;
        is_w   = 1'b1;
      end
      default: cls_ok = 1'b0;
    endcase
    wide_imm = WIDE && !is_reg && !is_w;
    hi_zero  = wide_imm ? (bus.inst[31:26] == 6'b000000)
                        : (bus.inst[31:25] == 7'b0000000);
    hi_sra   = wide_imm ? (bus.inst[31:26] == 6'b010000)
                        : (bus.inst[31:25] == 7'b0100000);
    left     = (f3 == 3'b001) && hi_zero;
    right    = (f3 == 3'b101) && (hi_zero || hi_sra);
    legal    = cls_ok && (left || right);
    raw_amt  = is_reg ? bus.rs2_dat[5:0] : bus.inst[25:20];
    amt      = {raw_amt[5] & WIDE & !is_w, raw_amt[4:0]};
    op_full  = {is_w, right & hi_sra, right, left};

    dec     = '0;
    dec.rd  = bus.inst[11:7];
    dec.ill = !legal;
    if (legal) begin
      dec.op = op_full[OPW-1:0];
      dec.s1 = bus.rs1_dat;
      dec.s2 = amt[SW-1:0];
    end
  end

  occ_t   state;
  occ_t   state_next;
  logic   rdy_q;
  logic   accept;
  logic   consume;
  logic   load_out_new;
  logic   load_out_skid;
  logic   load_skid;
  entry_t out_q;
  entry_t skid_q;

  assign accept  = bus.up_vld && rdy_q;
  assign consume = (state != EMPTY) && bus.dn_rdy;

  // Ready is registered from the next occupancy so dn_rdy never reaches up_rdy combinationally.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_next;
      rdy_q <= (state_next != FULL);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (consume && !accept)      state_next = EMPTY;
        else if (!consume && accept) state_next = FULL;
      end
      FULL:    if (consume) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    bus.dn_vld    = (state != EMPTY);
    bus.up_rdy    = rdy_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: load_out_new = accept;
      ONE: begin
        load_out_new = accept && consume;
        load_skid    = accept && !consume;
      end
      FULL:    load_out_skid = consume;
      default: load_out_new = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_new)       out_q <= dec;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
    end
  end

  assign bus.op      = out_q.op;
  assign bus.s1      = out_q.s1;
  assign bus.s2      = out_q.s2;
  assign bus.rd_idx  = out_q.rd;
  assign bus.illegal = out_q.ill;

  logic unused_bits;
  assign unused_bits = ^{bus.inst, bus.rs2_dat, op_full, amt};
endmodule
